// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: sequencer states and
// operation mode encodings.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/nibble_serial_adder_adder4.sv
// Combinational 4-bit ripple-carry slice built from gate-level full adders.
// c3 is the carry into bit 3, used by the caller for signed overflow.
module adder4
    import nibble_serial_adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       c3
);

    logic [4:0] c;

    assign c[0] = ci;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            logic p;
            assign p         = a[gi] ^ b[gi];
            assign s[gi]     = p ^ c[gi];
            assign c[gi + 1] = (a[gi] & b[gi]) | (p & c[gi]);
        end
    endgenerate

    assign co = c[4];
    assign c3 = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide add/subtract sequencer: one shared 4-bit slice processes one nibble
// per clock, LSB nibble first, with a start/busy/done handshake.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 zero
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_reg, state_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             load, step, last;

    logic [W-1:0]     a_reg, b_reg, sum_reg, sum_wr;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg, cout_reg, ovf_reg;

    logic [3:0]       a_nib [NIBBLES];
    logic [3:0]       b_nib [NIBBLES];
    logic [3:0]       slice_s;
    logic             slice_co, slice_c3;

    // Nibble views of the operands, and the sum with the current nibble replaced.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            localparam logic [IDX_W-1:0] NIB_IDX = IDX_W'(gi);
            assign a_nib[gi]            = a_reg[gi*4 +: 4];
            assign b_nib[gi]            = b_reg[gi*4 +: 4];
            assign sum_wr[gi*4 +: 4]    = (idx_reg == NIB_IDX) ? slice_s : sum_reg[gi*4 +: 4];
        end
    endgenerate

    adder4 u_slice (
        .a  (a_nib[idx_reg]),
        .b  (b_nib[idx_reg]),
        .ci (carry_reg),
        .s  (slice_s),
        .co (slice_co),
        .c3 (slice_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    busy_next  = 1'b1;
                    state_next = ST_ADD;
                end
            end
            ST_ADD: begin
                step      = 1'b1;
                busy_next = 1'b1;
                if (idx_reg == LAST_IDX) begin
                    last       = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted at load and carry-in forced high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (load) begin
            a_reg     <= a;
            b_reg     <= b ^ {W{sub}};
            carry_reg <= (sub == MODE_SUB) ? 1'b1 : cin;
            idx_reg   <= '0;
            sum_reg   <= '0;
        end else if (step) begin
            sum_reg   <= sum_wr;
            carry_reg <= slice_co;
            if (last) begin
                cout_reg <= slice_co;
                ovf_reg  <= slice_c3 ^ slice_co;
            end else begin
                idx_reg  <= idx_reg + 1'b1;
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
    assign zero = (sum_reg == '0);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed checks of nibble_serial_adder against an
// arithmetic reference model (NIBBLES = 4).
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, ovf, zero;
    logic [W-1:0] sum;

    int n_vec = 0;
    int n_bad = 0;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         input logic mcin, output logic [W-1:0] es, output logic ec,
                         output logic eo);
        int ua, ub, sa, sb, r, t;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!msub) begin
            t  = ua + ub + int'(mcin);
            es = W'(t);
            ec = (t >= (1 << W));
            r  = sa + sb + int'(mcin);
        end else begin
            es = ma - mb;
            ec = (ua >= ub);
            r  = sa - sb;
        end
        eo = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tsub, input logic tcin);
        logic [W-1:0] es;
        logic         ec, eo;
        int           lat, busy_cnt;
        model(ta, tb_v, tsub, tcin, es, ec, eo);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; sub = tsub; cin = tcin;
        lat = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                a = W'($urandom); b = W'($urandom);
                sub = 1'($urandom); cin = 1'($urandom);
            end
            if (done) lat = k;
            else if (busy) busy_cnt++;
        end
        check({tag, ".latency"}, lat, NIBBLES + 1);
        check({tag, ".busy_cycles"}, busy_cnt, NIBBLES);
        check({tag, ".sum"}, sum, es);
        check({tag, ".cout"}, cout, ec);
        check({tag, ".ovf"}, ovf, eo);
        check({tag, ".zero"}, zero, (es == '0));
        $display("op %s a=%h b=%h sub=%0d cin=%0d -> sum=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
                 tag, ta, tb_v, tsub, tcin, sum, cout, ovf, zero, lat);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int done_at [$];
        int busy_n;
        int d0, d1;

        repeat (2) @(negedge clk);
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.sum", sum, 0);
        check("reset.zero", zero, 1'b1);
        check("reset.cout", cout, 1'b0);
        check("reset.ovf", ovf, 1'b0);
        rst_n = 1'b1;

        run_op("add_basic",  16'h1234, 16'h1111, 1'b0, 1'b0);
        run_op("ripple",     16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0);
        run_op("sub_pos",    16'h0007, 16'h0005, 1'b1, 1'b1);
        run_op("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op("ovf_sub",    16'h8000, 16'h0001, 1'b1, 1'b0);

        // start held high for 10 cycles: accepts only at cycle 0 and right after done.
        @(negedge clk);
        start = 1'b1; a = 16'h0101; b = 16'h0202; sub = 1'b0; cin = 1'b0;
        busy_n = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 10) start = 1'b0;
            if (done) done_at.push_back(k);
            if (busy) busy_n++;
        end
        d0 = (done_at.size() > 0) ? done_at[0] : -1;
        d1 = (done_at.size() > 1) ? done_at[1] : -1;
        check("hold.done_count", done_at.size(), 2);
        check("hold.done0", d0, NIBBLES + 1);
        check("hold.done1", d1, 2 * NIBBLES + 3);
        check("hold.busy_cycles", busy_n, 2 * NIBBLES);
        check("hold.sum", sum, 16'h0303);
        $display("op hold start=10 cycles -> dones=%0d at %0d,%0d busy=%0d sum=%h",
                 done_at.size(), d0, d1, busy_n, sum);

        // Reset asserted after two ADD cycles.
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.busy", busy, 1'b0);
        check("midrst.done", done, 1'b0);
        check("midrst.sum", sum, 0);
        check("midrst.zero", zero, 1'b1);
        $display("op midreset -> busy=%0d done=%0d sum=%h zero=%0d", busy, done, sum, zero);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 16'hABCD, 16'h1357, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand%0d", i), W'($urandom), W'($urandom),
                   1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
